// File: rtl/io_resp_dev.sv
// IO responder: FIFO, status, control and scratch registers behind a
// wait-state handshake (IDLE -> WAIT -> ACK -> HOLD) on the IO request strobe.
module io_resp_dev #(
  parameter logic [5:0] BASE_ADDR   = 6'h20,
  parameter int         WAIT_CYCLES = 2
) (
  input  logic       sysclk,
  input  logic       sys_rst,
  input  logic       IORQ_n,
  input  logic       WRITE,
  input  logic [7:0] PA_7_0,
  input  logic       CLEAR_n,
  input  logic [7:0] IDB_7_0_IN,
  output logic [7:0] IDB_7_0_OUT,
  output logic       IDB_OE,
  output logic       RDY_n,
  output logic       INT_n
);
  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD, S_SKIP} state_t;
  typedef struct packed {
    logic [1:0] sel;
    logic       wr;
    logic [7:0] wdata;
  } io_req_t;

  state_t     state, state_nxt;
  io_req_t    req_q;
  logic [3:0] wcnt;
  logic       armed;
  logic       clr, do_acc;
  logic [7:0] fifo_mem [8];
  logic [2:0] wptr, rptr;
  logic [3:0] count;
  logic       full, empty, ovf, unf, ie;
  logic [7:0] scratch, rd_q, rdata;
  logic       int_n_q;

  assign clr   = sys_rst | ~CLEAR_n;
  assign full  = count[3];
  assign empty = (count == 4'd0);

  always_comb begin
    state_nxt = state;
    do_acc    = 1'b0;
    case (state)
      S_IDLE: if (!IORQ_n)
                state_nxt = (armed && PA_7_0[7:2] == BASE_ADDR) ? S_WAIT : S_SKIP;
      S_WAIT: if (IORQ_n) state_nxt = S_IDLE;
              else if (wcnt == WAIT_LIM) begin
                state_nxt = S_ACK;
                do_acc    = 1'b1;
              end
      S_ACK:  state_nxt = S_HOLD;
      S_HOLD: if (IORQ_n) state_nxt = S_IDLE;
      S_SKIP: if (IORQ_n) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // armed stays low after reset/clear until the strobe has been seen high,
  // so a request held across reset falls into SKIP instead of responding.
  always_ff @(posedge sysclk) begin
    if (clr) begin
      state <= S_IDLE;
      armed <= 1'b0;
      wcnt  <= 4'd0;
      req_q <= '0;
    end else begin
      state <= state_nxt;
      if (IORQ_n) armed <= 1'b1;
      if (state == S_WAIT) wcnt <= wcnt + 4'd1;
      else                 wcnt <= 4'd0;
      if (state == S_IDLE && state_nxt == S_WAIT)
        req_q <= '{sel: PA_7_0[1:0], wr: WRITE, wdata: IDB_7_0_IN};
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (req_q.sel)
      2'd0: rdata = empty ? 8'h00 : fifo_mem[rptr];
      2'd1: rdata = {ovf, unf, full, empty, count};
      2'd2: rdata = {7'b0, ie};
      2'd3: rdata = scratch;
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!clr && do_acc && req_q.wr && req_q.sel == 2'd0 && !full)
      fifo_mem[wptr] <= req_q.wdata;
  end

  // All register side effects and the read capture happen on entry to ACK.
  always_ff @(posedge sysclk) begin
    if (clr) begin
      wptr    <= 3'd0;
      rptr    <= 3'd0;
      count   <= 4'd0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      ie      <= 1'b0;
      scratch <= 8'h00;
      rd_q    <= 8'h00;
      int_n_q <= 1'b1;
    end else begin
      int_n_q <= ~(ie & ~empty);
      if (do_acc) begin
        if (req_q.wr) begin
          case (req_q.sel)
            2'd0: if (full) ovf <= 1'b1;
                  else begin
                    wptr  <= wptr + 3'd1;
                    count <= count + 4'd1;
                  end
            2'd2: begin
                    ie <= req_q.wdata[0];
                    if (req_q.wdata[7]) begin
                      ovf <= 1'b0;
                      unf <= 1'b0;
                    end
                  end
            2'd3: scratch <= req_q.wdata;
            default: ;
          endcase
        end else begin
          rd_q <= rdata;
          if (req_q.sel == 2'd0) begin
            if (empty) unf <= 1'b1;
            else begin
              rptr  <= rptr + 3'd1;
              count <= count - 4'd1;
            end
          end
        end
      end
    end
  end

  assign RDY_n       = ~(state == S_ACK || state == S_HOLD);
  assign IDB_OE      = (state == S_ACK || state == S_HOLD) && !req_q.wr;
  assign IDB_7_0_OUT = IDB_OE ? rd_q : 8'h00;
  assign INT_n       = int_n_q;
endmodule

// File: tb/tb_io_resp_dev.sv
// Directed bench for io_resp_dev: register map, FIFO limits, interrupt,
// foreign-address skip, clear/abort during WAIT, and reset.
module tb_io_resp_dev;
  localparam int         W      = 2;
  localparam logic [7:0] A_DATA = 8'h80;
  localparam logic [7:0] A_STAT = 8'h81;
  localparam logic [7:0] A_CTRL = 8'h82;
  localparam logic [7:0] A_SCR  = 8'h83;

  logic       sysclk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       IORQ_n = 1'b1;
  logic       WRITE = 1'b0;
  logic [7:0] PA_7_0 = 8'h00;
  logic       CLEAR_n = 1'b1;
  logic [7:0] IDB_7_0_IN = 8'h00;
  logic [7:0] IDB_7_0_OUT;
  logic       IDB_OE, RDY_n, INT_n;

  int n_chk = 0;
  int n_pass = 0;

  io_resp_dev #(.BASE_ADDR(6'h20), .WAIT_CYCLES(W)) dut (
    .sysclk(sysclk), .sys_rst(sys_rst), .IORQ_n(IORQ_n), .WRITE(WRITE),
    .PA_7_0(PA_7_0), .CLEAR_n(CLEAR_n), .IDB_7_0_IN(IDB_7_0_IN),
    .IDB_7_0_OUT(IDB_7_0_OUT), .IDB_OE(IDB_OE), .RDY_n(RDY_n), .INT_n(INT_n)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One full bus cycle; int_a/int_b are INT_n in the ACK and HOLD cycles.
  task automatic io_acc(input logic [7:0] addr, input logic wr, input logic [7:0] wd,
                        output logic [7:0] rd, output logic int_a, output logic int_b);
    int lat;
    logic oe, stable;
    @(posedge sysclk); #1;
    PA_7_0 = addr; WRITE = wr; IDB_7_0_IN = wd; IORQ_n = 1'b0;
    @(posedge sysclk);
    lat = 0;
    while (lat < 20) begin
      @(posedge sysclk); lat++;
      @(negedge sysclk);
      if (!RDY_n) break;
    end
    chk("latency", 32'(lat), 32'(W + 1));
    rd = IDB_7_0_OUT; oe = IDB_OE; int_a = INT_n;
    chk("oe", {31'b0, oe}, {31'b0, ~wr});
    @(negedge sysclk);
    stable = (IDB_7_0_OUT === rd) && (RDY_n === 1'b0);
    int_b = INT_n;
    chk("hold_stable", {31'b0, stable}, 32'd1);
    IORQ_n = 1'b1;
    @(negedge sysclk);
    chk("release", {23'b0, RDY_n, IDB_OE, IDB_7_0_OUT}, {23'b0, 1'b1, 1'b0, 8'h00});
  endtask

  task automatic wr_reg(input logic [7:0] addr, input logic [7:0] wd);
    logic [7:0] rd;
    logic a, b;
    io_acc(addr, 1'b1, wd, rd, a, b);
  endtask

  task automatic rd_reg(input logic [7:0] addr, output logic [7:0] rd);
    logic a, b;
    io_acc(addr, 1'b0, 8'h00, rd, a, b);
  endtask

  initial begin
    logic [7:0] d;
    logic ia, ib, quiet;

    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    chk("reset_outs", {21'b0, RDY_n, IDB_OE, INT_n, IDB_7_0_OUT}, {21'b0, 1'b1, 1'b0, 1'b1, 8'h00});
    @(posedge sysclk); #1 sys_rst = 1'b0;

    rd_reg(A_STAT, d);
    chk("status_init", d, 8'h10);
    wr_reg(A_SCR, 8'h5A);
    rd_reg(A_SCR, d);
    chk("scratch_rd", d, 8'h5A);

    for (int i = 1; i <= 9; i++) wr_reg(A_DATA, 8'(i));
    rd_reg(A_STAT, d);
    chk("status_full_ovf", d, {1'b1, 1'b0, 1'b1, 1'b0, 4'd8});
    for (int i = 1; i <= 8; i++) begin
      rd_reg(A_DATA, d);
      chk("pop_order", d, 8'(i));
    end
    rd_reg(A_DATA, d);
    chk("pop_empty", d, 8'h00);
    rd_reg(A_STAT, d);
    chk("status_unf", d, 8'hD0);
    wr_reg(A_CTRL, 8'h80);
    rd_reg(A_STAT, d);
    chk("status_flag_clr", d, 8'h10);

    wr_reg(A_CTRL, 8'h01);
    rd_reg(A_CTRL, d);
    chk("ctrl_rd", d, 8'h01);
    chk("int_idle_empty", {31'b0, INT_n}, 32'd1);
    io_acc(A_DATA, 1'b1, 8'h77, d, ia, ib);
    chk("int_push", {30'b0, ia, ib}, {30'b0, 1'b1, 1'b0});
    io_acc(A_DATA, 1'b0, 8'h00, d, ia, ib);
    chk("pop_int_data", d, 8'h77);
    chk("int_pop", {30'b0, ia, ib}, {30'b0, 1'b0, 1'b1});

    // foreign address: attempted scratch write must be ignored
    @(posedge sysclk); #1;
    PA_7_0 = 8'h47; WRITE = 1'b1; IDB_7_0_IN = 8'hFF; IORQ_n = 1'b0;
    quiet = 1'b1;
    repeat (8) begin
      @(negedge sysclk);
      if (RDY_n !== 1'b1 || IDB_OE !== 1'b0) quiet = 1'b0;
    end
    IORQ_n = 1'b1;
    chk("foreign_quiet", {31'b0, quiet}, 32'd1);
    rd_reg(A_SCR, d);
    chk("foreign_no_write", d, 8'h5A);

    // clear during WAIT of a push with three entries queued
    wr_reg(A_DATA, 8'hA1); wr_reg(A_DATA, 8'hA2); wr_reg(A_DATA, 8'hA3);
    rd_reg(A_STAT, d);
    chk("status_three", d, 8'h03);
    @(posedge sysclk); #1;
    PA_7_0 = A_DATA; WRITE = 1'b1; IDB_7_0_IN = 8'hEE; IORQ_n = 1'b0;
    @(posedge sysclk);
    @(posedge sysclk); #1 CLEAR_n = 1'b0;
    @(posedge sysclk); #1 CLEAR_n = 1'b1;
    quiet = 1'b1;
    repeat (8) begin
      @(negedge sysclk);
      if (RDY_n !== 1'b1) quiet = 1'b0;
    end
    IORQ_n = 1'b1;
    chk("clear_no_ack", {31'b0, quiet}, 32'd1);
    chk("clear_int", {31'b0, INT_n}, 32'd1);
    rd_reg(A_STAT, d);
    chk("clear_status", d, 8'h10);
    rd_reg(A_CTRL, d);
    chk("clear_ie", d, 8'h00);

    // abort a pop during WAIT
    wr_reg(A_DATA, 8'h11);
    @(posedge sysclk); #1;
    PA_7_0 = A_DATA; WRITE = 1'b0; IORQ_n = 1'b0;
    @(posedge sysclk);
    @(posedge sysclk); #1 IORQ_n = 1'b1;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge sysclk);
      if (RDY_n !== 1'b1 || IDB_OE !== 1'b0) quiet = 1'b0;
    end
    chk("abort_no_ack", {31'b0, quiet}, 32'd1);
    rd_reg(A_STAT, d);
    chk("abort_status", d, 8'h01);
    rd_reg(A_DATA, d);
    chk("abort_data_kept", d, 8'h11);

    // reset clears scratch
    wr_reg(A_SCR, 8'h3C);
    rd_reg(A_SCR, d);
    chk("scratch_rd2", d, 8'h3C);
    @(posedge sysclk); #1 sys_rst = 1'b1;
    repeat (2) @(posedge sysclk);
    #1 sys_rst = 1'b0;
    rd_reg(A_SCR, d);
    chk("reset_scratch", d, 8'h00);
    rd_reg(A_STAT, d);
    chk("reset_status", d, 8'h10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
